// File: rtl/adder_tree_acc_if.sv
// adder_tree_acc_if
//   Beat and result signals of the adder_tree_acc block.
//   master : producer side. Drives vld_i/first_i/last_i/data_i and observes acc_o/vld_o/ovf_o.
//   slave  : the adder_tree_acc block itself.
//   Signals:
//     vld_i    beat valid
//     first_i  beat opens a group (qualified by vld_i)
//     last_i   beat closes a group (qualified by vld_i)
//     data_i   NUM_IN packed signed lanes of IN_W bits, lane k at [k*IN_W +: IN_W]
//     acc_o    signed group sum, ACC_W bits, held between vld_o pulses
//     vld_o    one-cycle pulse marking a completed group on acc_o/ovf_o
//     ovf_o    group overflow flag, qualified by vld_o
interface adder_tree_acc_if #(
  parameter int NUM_IN = 16,
  parameter int IN_W   = 16,
  parameter int ACC_W  = 32
);
  logic                     vld_i;
  logic                     first_i;
  logic                     last_i;
  logic [NUM_IN*IN_W-1:0]   data_i;
  logic [ACC_W-1:0]         acc_o;
  logic                     vld_o;
  logic                     ovf_o;

  modport master (
    output vld_i, first_i, last_i, data_i,
    input  acc_o, vld_o, ovf_o
  );

  modport slave (
    input  vld_i, first_i, last_i, data_i,
    output acc_o, vld_o, ovf_o
  );
endinterface

// File: rtl/adder_tree_acc.sv
// adder_tree_acc
//   Pipelined signed adder tree followed by a group accumulator. Every beat reduces
//   NUM_IN signed lanes to one sum through LVL = $clog2(NUM_IN) registered levels;
//   the accumulate stage then sums tree results over a group framed by first_i/last_i
//   and publishes the group total with a one-cycle vld_o pulse.
//   Ports:
//     clk   rising-edge clock
//     rstn  asynchronous active-low reset; clears all pipeline state and outputs
//     bus   adder_tree_acc_if.slave (vld_i, first_i, last_i, data_i, acc_o, vld_o, ovf_o)
//   Parameters:
//     NUM_IN  lane count, power of 2 in 2..64
//     IN_W    signed lane width
//     ACC_W   accumulator/output width, must be >= IN_W + LVL
//   Build option:
//     ADDER_TREE_ACC_SAT_EN  defined   -> saturating accumulate with group-sticky ovf_o
//                            undefined -> two's-complement wrap, ovf_o tied to 0
module adder_tree_acc #(
  parameter int NUM_IN = 16,
  parameter int IN_W   = 16,
  parameter int ACC_W  = 32
) (
  input logic             clk,
  input logic             rstn,
  adder_tree_acc_if.slave bus
);

  localparam int LVL    = $clog2(NUM_IN);
  localparam int TREE_W = IN_W + LVL;

  // Tree levels. Level 0 is the raw lane split; each later level is a register
  // stage one bit wider than the one before, so pairwise sums never overflow.
  for (genvar j = 0; j <= LVL; j++) begin : g_lvl
    localparam int N = NUM_IN >> j;
    localparam int W = IN_W + j;

    logic signed [W-1:0] node [N];

    if (j == 0) begin : g_in
      // Unpack the lanes so level 1 can address them like any other level.
      always_comb begin
        for (int k = 0; k < N; k++) begin
          node[k] = bus.data_i[k*IN_W +: IN_W];
        end
      end
    end else begin : g_add
      // Sign-extend both children by one bit and register their sum.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int k = 0; k < N; k++) begin
            node[k] <= '0;
          end
        end else begin
          for (int k = 0; k < N; k++) begin
            node[k] <= {g_lvl[j-1].node[2*k][W-2],   g_lvl[j-1].node[2*k]}
                     + {g_lvl[j-1].node[2*k+1][W-2], g_lvl[j-1].node[2*k+1]};
          end
        end
      end
    end
  end

  // Beat qualifiers travel alongside the tree so they reach the accumulate
  // stage together with the sum they belong to. Bubbles are carried as vld=0.
  logic [LVL:1] vld_p;
  logic [LVL:1] first_p;
  logic [LVL:1] last_p;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p   <= '0;
      first_p <= '0;
      last_p  <= '0;
    end else begin
      vld_p[1]   <= bus.vld_i;
      first_p[1] <= bus.first_i;
      last_p[1]  <= bus.last_i;
      for (int i = 2; i <= LVL; i++) begin
        vld_p[i]   <= vld_p[i-1];
        first_p[i] <= first_p[i-1];
        last_p[i]  <= last_p[i-1];
      end
    end
  end

  logic signed [TREE_W-1:0] tree_sum;
  logic signed [ACC_W-1:0]  tree_ext;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]         acc_o_q;
  logic                     vld_o_q;

  assign tree_sum = g_lvl[LVL].node[0];
  assign tree_ext = ACC_W'(tree_sum);

`ifdef ADDER_TREE_ACC_SAT_EN
  localparam int SUM_W = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [SUM_W-1:0] sum_wide;
  logic                    clamp;
  logic                    ovf_q;
  logic                    ovf_next;
  logic                    ovf_o_q;

  // One guard bit catches signed overflow; the two top bits disagree exactly
  // when the true sum left the ACC_W range. A group opener can never clamp
  // because the tree result always fits in ACC_W.
  always_comb begin
    sum_wide = SUM_W'(acc_q) + SUM_W'(tree_ext);
    clamp    = 1'b0;
    acc_next = sum_wide[ACC_W-1:0];
    if (first_p[LVL]) begin
      acc_next = tree_ext;
    end else if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      clamp    = 1'b1;
      acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    ovf_next = (first_p[LVL] ? 1'b0 : ovf_q) | clamp;
  end

  // Sticky overflow for the open group, published with the group result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q   <= 1'b0;
      ovf_o_q <= 1'b0;
    end else if (vld_p[LVL]) begin
      ovf_q <= ovf_next;
      if (last_p[LVL]) begin
        ovf_o_q <= ovf_next;
      end
    end
  end

  assign bus.ovf_o = ovf_o_q;
`else
  // Plain two's-complement accumulate; wraps silently at ACC_W.
  always_comb begin
    acc_next = first_p[LVL] ? tree_ext : acc_q + tree_ext;
  end

  assign bus.ovf_o = 1'b0;
`endif

  // Accumulate stage. Only valid beats touch the accumulator; acc_o moves only
  // together with a vld_o pulse, so it holds the last group total otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q   <= '0;
      acc_o_q <= '0;
      vld_o_q <= 1'b0;
    end else begin
      vld_o_q <= vld_p[LVL] & last_p[LVL];
      if (vld_p[LVL]) begin
        acc_q <= acc_next;
        if (last_p[LVL]) begin
          acc_o_q <= acc_next;
        end
      end
    end
  end

  assign bus.acc_o = acc_o_q;
  assign bus.vld_o = vld_o_q;

endmodule

// File: tb/tb_adder_tree_acc.sv
// tb_adder_tree_acc
//   Self-checking bench for adder_tree_acc (NUM_IN=16, IN_W=16, ACC_W=20, so the
//   accumulator width equals the tree width and group overflow is easy to reach).
//   Stimulus pushes expected group results into a queue; a negedge monitor pops
//   and compares them, and also checks that outputs hold between pulses and read
//   zero under reset. Honours ADDER_TREE_ACC_SAT_EN like the design.
module tb_adder_tree_acc;

  localparam int NUM_IN = 16;
  localparam int IN_W   = 16;
  localparam int ACC_W  = 20;
  localparam int LVL    = $clog2(NUM_IN);
  localparam int DW     = NUM_IN * IN_W;
  localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ACC_W - 1));

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
    int               cyc;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t   exp_q[$];
  longint model_acc = 0;
  bit     model_ovf = 1'b0;

  logic [ACC_W-1:0] held_acc = '0;
  logic             held_ovf = 1'b0;

  adder_tree_acc_if #(.NUM_IN(NUM_IN), .IN_W(IN_W), .ACC_W(ACC_W)) bus ();

  adder_tree_acc #(.NUM_IN(NUM_IN), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Cycle stamp used to check output latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Compare outputs away from the active edge.
  always @(negedge clk) checkOutput();

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint laneSum(input logic [DW-1:0] d);
    longint s = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      s += longint'($signed(d[k*IN_W +: IN_W]));
    end
    return s;
  endfunction

  // Group arithmetic straight from the block's rules on plain integers.
  task automatic modelBeat(input bit f, input bit l, input logic [DW-1:0] d);
    longint nxt;
    bit     clamp = 1'b0;
    exp_t   e;
    nxt = f ? laneSum(d) : model_acc + laneSum(d);
`ifdef ADDER_TREE_ACC_SAT_EN
    if (nxt > ACC_MAX) begin
      nxt   = ACC_MAX;
      clamp = 1'b1;
    end else if (nxt < ACC_MIN) begin
      nxt   = ACC_MIN;
      clamp = 1'b1;
    end
    model_ovf = (f ? 1'b0 : model_ovf) | clamp;
`else
    begin
      logic signed [ACC_W-1:0] w;
      w   = nxt[ACC_W-1:0];
      nxt = longint'(w);
    end
`endif
    model_acc = nxt;
    if (l) begin
      e.acc = nxt[ACC_W-1:0];
      e.ovf = model_ovf;
      e.cyc = cyc + LVL + 1;
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [DW-1:0] randData();
    logic [DW-1:0]   d;
    logic [IN_W-1:0] lane;
    if ($urandom_range(0, 3) == 0) begin
      lane = IN_W'($urandom);
      d    = {NUM_IN{lane}};
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        d[k*IN_W +: IN_W] = IN_W'($urandom);
      end
    end
    return d;
  endfunction

  task automatic applyStimulus(input bit v, input bit f, input bit l, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    bus.vld_i   = v;
    bus.first_i = f;
    bus.last_i  = l;
    bus.data_i  = d;
    if (v) modelBeat(f, l, d);
  endtask

  // Bubbles carry random qualifiers and data that must all be ignored.
  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), randData());
  endtask

  task automatic doReset(input int n);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    exp_q.delete();
    model_acc = 0;
    model_ovf = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.vld_i   = 1'($urandom_range(0, 1));
      bus.first_i = 1'($urandom_range(0, 1));
      bus.last_i  = 1'($urandom_range(0, 1));
      bus.data_i  = randData();
    end
    bus.vld_i = 1'b0;
    rstn      = 1'b1;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (!rstn) begin
      cmp("rst_vld_o", 64'(bus.vld_o), 64'd0);
      cmp("rst_acc_o", 64'(bus.acc_o), 64'd0);
      cmp("rst_ovf_o", 64'(bus.ovf_o), 64'd0);
      held_acc = '0;
      held_ovf = 1'b0;
    end else if (bus.vld_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_vld_o: got vld_o=1 expected no result (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        cmp("acc_o",   64'(bus.acc_o), 64'(e.acc));
        cmp("ovf_o",   64'(bus.ovf_o), 64'(e.ovf));
        cmp("latency", 64'(cyc),       64'(e.cyc));
        held_acc = e.acc;
        held_ovf = e.ovf;
      end
    end else begin
      cmp("hold_acc_o", 64'(bus.acc_o), 64'(held_acc));
      cmp("hold_ovf_o", 64'(bus.ovf_o), 64'(held_ovf));
    end
  endtask

  // Directed scenarios first, then a randomised stream, then drain the queue.
  initial begin
    bus.vld_i   = 1'b0;
    bus.first_i = 1'b0;
    bus.last_i  = 1'b0;
    bus.data_i  = '0;

    $display("[TB] reset with random inputs");
    doReset(6);
    idle(2);

    $display("[TB] single-beat group of ones");
    applyStimulus(1'b1, 1'b1, 1'b1, {NUM_IN{16'h0001}});
    idle(8);

    $display("[TB] four-beat group of -1");
    applyStimulus(1'b1, 1'b1, 1'b0, {NUM_IN{16'hFFFF}});
    applyStimulus(1'b1, 1'b0, 1'b0, {NUM_IN{16'hFFFF}});
    applyStimulus(1'b1, 1'b0, 1'b0, {NUM_IN{16'hFFFF}});
    applyStimulus(1'b1, 1'b0, 1'b1, {NUM_IN{16'hFFFF}});
    idle(8);

    $display("[TB] back-to-back groups and a bubble inside a group");
    applyStimulus(1'b1, 1'b1, 1'b0, {NUM_IN{16'h0001}});
    applyStimulus(1'b1, 1'b0, 1'b1, {NUM_IN{16'h0002}});
    applyStimulus(1'b1, 1'b1, 1'b0, {NUM_IN{16'h0001}});
    applyStimulus(1'b1, 1'b0, 1'b1, {NUM_IN{16'h0002}});
    applyStimulus(1'b1, 1'b1, 1'b0, {NUM_IN{16'h0001}});
    idle(3);
    applyStimulus(1'b1, 1'b0, 1'b1, {NUM_IN{16'h0002}});
    idle(8);

    $display("[TB] overflowing group of max positive lanes");
    applyStimulus(1'b1, 1'b1, 1'b0, {NUM_IN{16'h7FFF}});
    applyStimulus(1'b1, 1'b0, 1'b1, {NUM_IN{16'h7FFF}});
    idle(8);

    $display("[TB] reset inside an open group");
    applyStimulus(1'b1, 1'b1, 1'b0, randData());
    applyStimulus(1'b1, 1'b0, 1'b0, randData());
    doReset(2);
    applyStimulus(1'b1, 1'b1, 1'b1, {NUM_IN{16'h0003}});
    idle(8);

    $display("[TB] random stream");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0),
                    randData());
    end
    idle(2);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d results outstanding expected 0", exp_q.size());
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
